// File: rtl/byte_striping_pkg.sv
// Shared definitions for the byte striping transmit/receive pair: lane count
// encodings, default pad byte and the striper state encoding.
package byte_striping_pkg;

    localparam int          NUM_LANES        = 4;
    localparam logic [2:0]  LANES_1          = 3'd1;
    localparam logic [2:0]  LANES_2          = 3'd2;
    localparam logic [2:0]  LANES_4          = 3'd4;
    localparam logic [7:0]  PAD_BYTE_DEFAULT = 8'h00;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RSVD1 = 2'd1,
        ST_RSVD2 = 2'd2,
        ST_RSVD3 = 2'd3
    } stripe_state_t;

    // Unrecognised lane-count encodings fall back to the full four lanes.
    function automatic logic [2:0] decode_lanes(input logic [2:0] active_lanes);
        case (active_lanes)
            LANES_1: decode_lanes = LANES_1;
            LANES_2: decode_lanes = LANES_2;
            default: decode_lanes = LANES_4;
        endcase
    endfunction

endpackage

// File: rtl/byte_stripingtx.sv
// Transmit-side byte striper: distributes a serial byte stream round-robin over
// up to four lanes. Optional parity output enabled by BYTE_STRIPING_PARITY_EN.
module byte_stripingtx
    import byte_striping_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE = PAD_BYTE_DEFAULT,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [7:0]       data,
    input  logic [2:0]       active_lanes,
    output logic [7:0]       data_out0,
    output logic [7:0]       data_out1,
    output logic [7:0]       data_out2,
    output logic [7:0]       data_out3,
    output logic             valid_out,
    output logic [3:0]       lane_valid,
    output logic [CNT_W-1:0] group_count
`ifdef BYTE_STRIPING_PARITY_EN
    ,
    output logic [3:0]       parity
`endif
);

    stripe_state_t                   state_q, state_d;
    logic [1:0]                      idx_q, idx_d;
    logic [2:0]                      n_q, n_d;
    logic [NUM_LANES-1:0][7:0]       hold_q, hold_d;
    logic [NUM_LANES-1:0][7:0]       dout_q, dout_d;
    logic                            valid_out_q, valid_out_d;
    logic [NUM_LANES-1:0]            lane_valid_q, lane_valid_d;
    logic [CNT_W-1:0]                count_q, count_d;
    logic                            emit;
    logic [2:0]                      fill;
`ifdef BYTE_STRIPING_PARITY_EN
    logic [NUM_LANES-1:0]            parity_q, parity_d;
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        n_d          = n_q;
        hold_d       = hold_q;
        dout_d       = dout_q;
        valid_out_d  = 1'b0;
        lane_valid_d = lane_valid_q;
        count_d      = count_q;
        emit         = 1'b0;
        fill         = 3'd0;
`ifdef BYTE_STRIPING_PARITY_EN
        parity_d     = parity_q;
`endif

        case (state_q)
            ST_FILL: begin
                // Lane count only moves at a group boundary so a group never
                // changes width halfway through.
                if (idx_q == 2'd0) begin
                    n_d = decode_lanes(active_lanes);
                end
                if (valid) begin
                    hold_d[idx_q] = data;
                    if ({1'b0, idx_q} == n_d - 3'd1) begin
                        emit  = 1'b1;
                        fill  = n_d;
                        idx_d = 2'd0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else if (idx_q != 2'd0) begin
                    emit  = 1'b1;
                    fill  = {1'b0, idx_q};
                    idx_d = 2'd0;
                end
            end
            default: begin
                state_d = ST_FILL;
                idx_d   = 2'd0;
            end
        endcase

        // hold_d already carries the byte arriving this cycle.
        if (emit) begin
            valid_out_d = 1'b1;
            count_d     = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            for (int k = 0; k < NUM_LANES; k++) begin
                if (k < int'(fill)) begin
                    dout_d[k]       = hold_d[k];
                    lane_valid_d[k] = 1'b1;
                end else begin
                    dout_d[k]       = PAD_BYTE;
                    lane_valid_d[k] = 1'b0;
                end
`ifdef BYTE_STRIPING_PARITY_EN
                parity_d[k] = lane_valid_d[k] ? ^dout_d[k] : 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_FILL;
            idx_q        <= 2'd0;
            n_q          <= LANES_4;
            hold_q       <= '0;
            dout_q       <= '0;
            valid_out_q  <= 1'b0;
            lane_valid_q <= '0;
            count_q      <= '0;
`ifdef BYTE_STRIPING_PARITY_EN
            parity_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            n_q          <= n_d;
            hold_q       <= hold_d;
            dout_q       <= dout_d;
            valid_out_q  <= valid_out_d;
            lane_valid_q <= lane_valid_d;
            count_q      <= count_d;
`ifdef BYTE_STRIPING_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign data_out0   = dout_q[0];
    assign data_out1   = dout_q[1];
    assign data_out2   = dout_q[2];
    assign data_out3   = dout_q[3];
    assign valid_out   = valid_out_q;
    assign lane_valid  = lane_valid_q;
    assign group_count = count_q;
`ifdef BYTE_STRIPING_PARITY_EN
    assign parity      = parity_q;
`endif

endmodule
